// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths and the target state encoding.
// Used by both the target and any initiator in this codebase.
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StReg,
        StRegAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StIgnore
    } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizers for scl/sda plus scl edge and START/STOP detection.
// Detection is held off until the chain has refilled after reset.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic [1:0] fill_q;
    logic       scl_s;
    logic       armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            fill_q     <= 2'd0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign armed     = (fill_q == 2'd3);
    assign scl_rise  = armed & scl_s & ~scl_prev_q;
    assign scl_fall  = armed & ~scl_s & scl_prev_q;
    assign start_det = armed & scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = armed & scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a 2**REG_AW x 8 register file, write strobes and register reads.
// Define I2C_SLAVE_AUTOINC_EN to advance the register pointer after each data byte.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h41,
    parameter int unsigned       REG_AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              wr_valid,
    output logic [REG_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam int unsigned NREGS = 2 ** REG_AW;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [REG_AW-1:0]   ptr_q, ptr_d, ptr_adv;
    logic                sda_oe_q, sda_oe_d;
    logic                rw_q, rw_d;
    logic                busy_q, busy_d;
    logic                wr_valid_q, wr_valid_d;
    logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   regs_q [NREGS];

    logic                sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [DATA_W-1:0]   byte_in, rd_byte, next_byte;
    logic                last_bit, addr_match;

    i2c_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

`ifdef I2C_SLAVE_AUTOINC_EN
    assign ptr_adv = ptr_q + 1'b1;
`else
    assign ptr_adv = ptr_q;
`endif

    assign byte_in    = {shift_q[DATA_W-2:0], sda_s};
    assign last_bit   = (bit_cnt_q == 3'd7);
    assign addr_match = (byte_in[DATA_W-1:1] == SLAVE_ADDR);
    assign rd_byte    = regs_q[ptr_q];
    assign next_byte  = regs_q[ptr_adv];

    // Open drain: only ever pull low; the flop's async reset releases the line at once.
    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ACK states use sda_oe_q as their phase: first falling edge drives, second releases.
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = StIdle;
        end else if (start_det) begin
            state_d = StAddr;
        end else begin
            case (state_q)
                StAddr:     if (scl_rise && last_bit) state_d = addr_match ? StAddrAck : StIgnore;
                StAddrAck:  if (scl_fall && sda_oe_q) state_d = rw_q ? StRdata : StReg;
                StReg:      if (scl_rise && last_bit) state_d = StRegAck;
                StRegAck:   if (scl_fall && sda_oe_q) state_d = StWdata;
                StWdata:    if (scl_rise && last_bit) state_d = StWdataAck;
                StWdataAck: if (scl_fall && sda_oe_q) state_d = StWdata;
                StRdata:    if (scl_rise && last_bit) state_d = StRdataAck;
                StRdataAck: if (scl_rise) state_d = sda_s ? StIgnore : StRdata;
                default:    state_d = state_q;
            endcase
        end
    end

    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (stop_det) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (start_det) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                StAddr, StReg, StWdata: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit && state_q == StAddr) begin
                            rw_d = byte_in[0];
                            if (addr_match) busy_d = 1'b1;
                        end
                        if (last_bit && state_q == StReg) begin
                            ptr_d = byte_in[REG_AW-1:0];
                        end
                        if (last_bit && state_q == StWdata) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = byte_in;
                            ptr_d      = ptr_adv;
                        end
                    end
                end
                StAddrAck, StRegAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            // The ACK-ending edge also puts the first read bit on the bus.
                            if (state_q == StAddrAck && rw_q) begin
                                sda_oe_d = ~rd_byte[DATA_W-1];
                                shift_d  = {rd_byte[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        sda_oe_d = ~shift_q[DATA_W-1];
                        shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                    end
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                StRdataAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end
                    if (scl_rise && !sda_s) begin
                        ptr_d     = ptr_adv;
                        shift_d   = next_byte;
                        bit_cnt_d = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            bit_cnt_q  <= 3'd0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            if (wr_valid_d) begin
                regs_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h41, is the 7-bit bus address this target answers to.
REQ-002 Parameter REG_AW, default 4, is the register-file address width (16 x 8-bit registers).
REQ-003 Port clk  input  1  system clock, at least 8x the SCL frequency; one clock.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port scl  input  1  bus clock from the initiator, asynchronous to clk.
REQ-006 Port sda  inout  1  open-drain data; the block drives only 0 or high-Z, and an external pullup supplies the high level.
REQ-007 Port wr_valid  output  1  one-clk pulse for each register written from the bus.
REQ-008 Port wr_addr  output  REG_AW  register index of the current write, valid with wr_valid.
REQ-009 Port wr_data  output  8  data of the current write, valid with wr_valid.
REQ-010 Port busy  output  1  high from a START addressed to this block until the following STOP.

Function
REQ-011 scl and sda each pass through a 2-flop synchronizer; all detection uses the synchronized values.
- START: sda falls while scl is high.
- STOP: sda rises while scl is high.
- Bits are sampled on the synchronized scl rising edge.
REQ-012 The state machine has these states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-013 START in any state shall go to ADDR and clear the bit counter (this covers repeated START).
- STOP in any state shall go to IDLE and release sda.
REQ-014 ADDR shifts in 8 bits MSB first.
- If bits[7:1] equal SLAVE_ADDR, go to ADDR_ACK.
- Otherwise go to IGNORE and never drive sda until the next START or STOP.
REQ-015 ACK timing.
- sda is driven low from the first synchronized scl falling edge after the 8th bit.
- sda is released at the next scl falling edge.
- ACK is driven in ADDR_ACK, REG_ACK and WDATA_ACK.
REQ-016 After ADDR_ACK: if R/W=0, go to REG; if R/W=1, load the shift register with reg[ptr] and go to RDATA.
REQ-017 REG receives a byte, sets ptr to its low REG_AW bits (upper bits ignored), and goes to REG_ACK, then WDATA.
REQ-018 WDATA receives a byte, then goes to WDATA_ACK.
- At the 8th rising edge: write reg[ptr], and pulse wr_valid with wr_addr=ptr and wr_data=byte.
REQ-019 RDATA shifts data MSB first.
- sda is updated at each scl falling edge, and is released (high-Z) for every 1 bit.
- After 8 bits go to RDATA_ACK and release sda.
- Sampled sda=0 (ACK): reload from reg[ptr] and go to RDATA.
- Sampled sda=1 (NACK): go to IGNORE.
REQ-020 Pointer arithmetic is modulo 2^REG_AW; 4'hF+1 wraps to 4'h0.
REQ-021 Read-only bus access never asserts wr_valid.

Reset
REQ-022 Reset values:
- state=IDLE, ptr=0, bit counter=0, sda released.
- wr_valid=0, wr_addr=0, wr_data=0, busy=0.
- all registers = 8'h00.
REQ-023 Reset asserted mid-transfer shall release sda in the same cycle, asynchronously.
REQ-024 After reset, the block ignores the bus until a fresh START.

Configuration
REQ-025 Macro I2C_SLAVE_AUTOINC_EN.
- Defined: ptr increments by 1 after each WDATA byte and after each ACKed RDATA byte.
- Undefined: ptr stays fixed for the whole transaction.

Structure
REQ-026 Package i2c_pkg holds the state encoding constants, the address width of 7, and the data width of 8; the initiator shares it.
REQ-027 Sub-module i2c_sync_edge holds the synchronizer plus edge detection.
- Outputs: scl_rise, scl_fall, start_det, stop_det.
- Instanced once, for scl/sda.

Verification
REQ-028 Write 0xB7 to register 0x1.
- Stimulus: START, 0x82 (addr 0x41, W), 0xF1, 0xB7, STOP.
- Response: three ACKs; wr_valid pulses once with wr_addr=1 and wr_data=0xB7; busy=0 after STOP.
REQ-029 Address mismatch.
- Stimulus: START, 0xC8 (addr 0x64).
- Response: sda never driven low; state=IGNORE; no wr_valid.
REQ-030 Random read with repeated START.
- Stimulus: START, 0x82, 0x01, repeated START, 0x83, master NACK, STOP.
- Response: 0xB7 returned MSB first; IGNORE, then IDLE.
REQ-031 Auto-increment with I2C_SLAVE_AUTOINC_EN defined.
- Stimulus: write 0x11, 0x22 starting at register 0xF.
- Response: reg[15]=0x11, reg[0]=0x22 (wrap).
- Without the macro, reg[15]=0x22.
REQ-032 Reset mid-transfer.
- Stimulus: rst=1 during the ADDR_ACK low phase.
- Response: sda is Z immediately; the next full write transaction succeeds.
